// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Provides the data/register index types, the registered write payload,
// and the source index constants used for src_* port vectors.
package rf_wb_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_ind_t;

    // One pending register-file write
    typedef struct packed {
        logic     valid;
        reg_ind_t addr;
        data_t    data;
    } wb_req_t;

    localparam int unsigned WB_SRC_EXE = 0;
    localparam int unsigned WB_SRC_MEM = 1;

endpackage

// File: rtl/rf_wb_arbiter_prio_arb.sv
// rf_wb_prio_arb: fixed-priority grant among dbg, EXE (src0) and MEM (src1),
// with a saturating starvation counter that force-grants EXE.
// Ports:
//   clk, rstn         clock / async active-low reset
//   dbg_we            debug write request (highest priority, no handshake)
//   src_valid[1:0]    per-source request (bit0=EXE, bit1=MEM)
//   grant[1:0]        one-hot source grant (combinational)
//   grant_dbg         debug port wins this cycle (combinational)
module rf_wb_prio_arb
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       dbg_we,
    input  logic [1:0] src_valid,
    output logic [1:0] grant,
    output logic       grant_dbg
);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Grant selection, at most one winner per cycle
    always_comb begin
        grant     = 2'b00;
        grant_dbg = 1'b0;
        if (dbg_we) begin
            grant_dbg = 1'b1;
        end else if (src_valid[WB_SRC_EXE] && starved) begin
            grant[WB_SRC_EXE] = 1'b1;
        end else if (src_valid[WB_SRC_MEM]) begin
            grant[WB_SRC_MEM] = 1'b1;
        end else if (src_valid[WB_SRC_EXE]) begin
            grant[WB_SRC_EXE] = 1'b1;
        end
    end

    // Count consecutive waiting cycles of EXE; saturate at the limit
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!src_valid[WB_SRC_EXE] || grant[WB_SRC_EXE]) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port among the EXE
// result (src0), MEM load result (src1) and a debug/init port. The selected
// write is registered for one cycle and then drives RegFile we/addr/data.
// Optional read-side forwarding of the registered write: macro RF_WB_FWD_EN.
// Ports:
//   clk, rstn                 clock / async active-low reset
//   src_valid/addr/data       per-source write request (bit0=EXE, bit1=MEM)
//   src_ready                 per-source accept (transfer = valid & ready)
//   dbg_we/addr/data          debug write, highest priority
//   rf_we/waddr/wdata         to RegFile write port
//   fwd_raddr_1/2             read addresses checked against the pending write
//   fwd_hit_1/2, fwd_data_1/2 forwarding result
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          src_valid,
    input  reg_ind_t [1:0]      src_addr,
    input  data_t    [1:0]      src_data,
    output logic [1:0]          src_ready,
    input  logic                dbg_we,
    input  reg_ind_t            dbg_addr,
    input  data_t               dbg_data,
    output logic                rf_we,
    output reg_ind_t            rf_waddr,
    output data_t               rf_wdata,
    input  reg_ind_t            fwd_raddr_1,
    input  reg_ind_t            fwd_raddr_2,
    output logic                fwd_hit_1,
    output logic                fwd_hit_2,
    output data_t               fwd_data_1,
    output data_t               fwd_data_2
);

    logic [1:0] grant;
    logic       grant_dbg;
    wb_req_t    wb_q;
    wb_req_t    wb_d;

    rf_wb_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .dbg_we    (dbg_we),
        .src_valid (src_valid),
        .grant     (grant),
        .grant_dbg (grant_dbg)
    );

    assign src_ready = grant;

    // Capture the winner; with no winner only valid drops, addr/data hold
    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        if (grant_dbg) begin
            wb_d = '{valid: 1'b1, addr: dbg_addr, data: dbg_data};
        end else if (grant[WB_SRC_MEM]) begin
            wb_d = '{valid: 1'b1, addr: src_addr[WB_SRC_MEM], data: src_data[WB_SRC_MEM]};
        end else if (grant[WB_SRC_EXE]) begin
            wb_d = '{valid: 1'b1, addr: src_addr[WB_SRC_EXE], data: src_data[WB_SRC_EXE]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    // x0 writes are accepted but never reach the RegFile
    assign rf_we    = wb_q.valid && (wb_q.addr != '0);
    assign rf_waddr = wb_q.addr;
    assign rf_wdata = wb_q.data;

`ifdef RF_WB_FWD_EN
    // Bridges the cycle before the RegFile update is visible on reads
    assign fwd_hit_1  = rf_we && (wb_q.addr == fwd_raddr_1);
    assign fwd_hit_2  = rf_we && (wb_q.addr == fwd_raddr_2);
    assign fwd_data_1 = fwd_hit_1 ? wb_q.data : '0;
    assign fwd_data_2 = fwd_hit_2 ? wb_q.data : '0;
`else
    logic fwd_unused;
    assign fwd_unused = ^{fwd_raddr_1, fwd_raddr_2};
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data_1 = '0;
    assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_LIMIT=4).
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic            clk;
    logic            rstn;
    logic [1:0]      src_valid;
    reg_ind_t [1:0]  src_addr;
    data_t    [1:0]  src_data;
    logic [1:0]      src_ready;
    logic            dbg_we;
    reg_ind_t        dbg_addr;
    data_t           dbg_data;
    logic            rf_we;
    reg_ind_t        rf_waddr;
    data_t           rf_wdata;
    reg_ind_t        fwd_raddr_1, fwd_raddr_2;
    logic            fwd_hit_1, fwd_hit_2;
    data_t           fwd_data_1, fwd_data_2;

    int tests;
    int fails;

`ifdef RF_WB_FWD_EN
    localparam logic [31:0] FWD_ON = 32'd1;
`else
    localparam logic [31:0] FWD_ON = 32'd0;
`endif

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .src_valid   (src_valid),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_raddr_1 (fwd_raddr_1),
        .fwd_raddr_2 (fwd_raddr_2),
        .fwd_hit_1   (fwd_hit_1),
        .fwd_hit_2   (fwd_hit_2),
        .fwd_data_1  (fwd_data_1),
        .fwd_data_2  (fwd_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_rdy [6];
        logic [4:0] exp_adr [6];
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        src_valid = 2'b00;
        src_addr = '0;
        src_data = '0;
        dbg_we = 1'b0;
        dbg_addr = '0;
        dbg_data = '0;
        fwd_raddr_1 = '0;
        fwd_raddr_2 = '0;

        // Reset state
        #12;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit_1), 32'd0);
        rstn = 1'b1;
        tick();

        // Single MEM write
        src_valid = 2'b10; src_addr[1] = 5'd5; src_data[1] = 32'hAB;
        #1;
        chk("single_ready", 32'(src_ready), 32'b10);
        tick();
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hAB);
        src_valid = 2'b00;
        #1;
        chk("idle_ready", 32'(src_ready), 32'd0);
        tick();
        chk("idle_we", 32'(rf_we), 32'd0);
        chk("idle_hold_addr", 32'(rf_waddr), 32'd5);
        chk("idle_hold_data", rf_wdata, 32'hAB);

        // Debug priority over both sources
        dbg_we = 1'b1; dbg_addr = 5'd3; dbg_data = 32'h33;
        src_valid = 2'b11;
        src_addr[0] = 5'd9;  src_data[0] = 32'h99;
        src_addr[1] = 5'd10; src_data[1] = 32'h1010;
        #1;
        chk("dbg_ready", 32'(src_ready), 32'd0);
        tick();
        chk("dbg_waddr", 32'(rf_waddr), 32'd3);
        chk("dbg_wdata", rf_wdata, 32'h33);
        chk("dbg_we", 32'(rf_we), 32'd1);
        dbg_we = 1'b0;
        src_valid = 2'b00;
        tick();

        // Starvation: MEM four times, then EXE forced, then MEM again
        exp_rdy = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        exp_adr = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd9, 5'd10};
        src_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("starve_ready_%0d", i), 32'(src_ready), 32'(exp_rdy[i]));
            tick();
            chk($sformatf("starve_waddr_%0d", i), 32'(rf_waddr), 32'(exp_adr[i]));
        end
        src_valid = 2'b00;
        tick();

        // Debug held continuously: sources stall, EXE wins first free cycle
        dbg_we = 1'b1; dbg_addr = 5'd4; dbg_data = 32'h44;
        src_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("dbg_hold_ready_%0d", i), 32'(src_ready), 32'd0);
            tick();
        end
        chk("dbg_hold_waddr", 32'(rf_waddr), 32'd4);
        dbg_we = 1'b0;
        #1;
        chk("post_dbg_ready", 32'(src_ready), 32'b01);
        tick();
        chk("post_dbg_waddr", 32'(rf_waddr), 32'd9);
        src_valid = 2'b00;
        tick();

        // x0 write accepted and dropped
        src_valid = 2'b01; src_addr[0] = 5'd0; src_data[0] = 32'hFF;
        fwd_raddr_1 = 5'd0;
        #1;
        chk("x0_ready", 32'(src_ready), 32'b01);
        tick();
        chk("x0_we", 32'(rf_we), 32'd0);
        chk("x0_waddr", 32'(rf_waddr), 32'd0);
        chk("x0_wdata", rf_wdata, 32'hFF);
        chk("x0_fwd_hit", 32'(fwd_hit_1), 32'd0);

        // Forwarding of the registered write
        src_valid = 2'b10; src_addr[1] = 5'd7; src_data[1] = 32'h1234;
        fwd_raddr_1 = 5'd7; fwd_raddr_2 = 5'd8;
        tick();
        chk("fwd_hit_1", 32'(fwd_hit_1), FWD_ON);
        chk("fwd_data_1", fwd_data_1, FWD_ON * 32'h1234);
        chk("fwd_hit_2", 32'(fwd_hit_2), 32'd0);
        chk("fwd_data_2", fwd_data_2, 32'd0);

        // Reset during an in-flight write
        src_addr[1] = 5'd12; src_data[1] = 32'hC0DE;
        tick();
        chk("pre_rst_we", 32'(rf_we), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
        chk("mid_rst_wdata", rf_wdata, 32'd0);
        src_valid = 2'b00;
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_we", 32'(rf_we), 32'd0);
        chk("post_rst_waddr", 32'(rf_waddr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
